// File: rtl/dir_button_conditioner.sv
// ============================================================================
// Module   : dir_button_conditioner
// Brief    : Synchronises, debounces and arbitrates four direction pushbuttons
//            into single-cycle move pulses (n > s > e > w, chord lockout).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dir_button_conditioner #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  output logic n,
  output logic s,
  output logic e,
  output logic w,
  output logic busy
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // Channel index: 0 = north, 1 = south, 2 = east, 3 = west
  logic [3:0] w_raw;
  logic [3:0] w_db;
  logic [3:0] w_db_nxt;
  logic [3:0] w_rise;
  logic [3:0] pulse_q, pulse_d;
  logic       busy_q, busy_d;

  assign w_raw = {btn_w, btn_e, btn_s, btn_n};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_chan
      logic             s1_q, s2_q;
      logic             db_q, db_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          db_q  <= 1'b0;
          cnt_q <= '0;
        end else begin
          s1_q  <= w_raw[i];
          s2_q  <= s1_q;
          db_q  <= db_d;
          cnt_q <= cnt_d;
        end
      end

      // Any sample agreeing with the debounced level restarts the count.
      always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (s2_q == db_q) begin
          cnt_d = '0;
        end else if (cnt_q == C_CNT_MAX) begin
          db_d  = s2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      assign w_db[i]     = db_q;
      assign w_db_nxt[i] = db_d;
    end
  endgenerate

  assign w_rise = w_db_nxt & ~w_db;

  // A rising channel has db=0, so "another channel already held" reduces to
  // "any channel already held"; rises losing priority are simply dropped.
  always_comb begin
    pulse_d = 4'b0000;
    busy_d  = |w_db_nxt;
    if (w_db == 4'b0000) begin
      if (w_rise[0])      pulse_d = 4'b0001;
      else if (w_rise[1]) pulse_d = 4'b0010;
      else if (w_rise[2]) pulse_d = 4'b0100;
      else if (w_rise[3]) pulse_d = 4'b1000;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_q <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign n    = pulse_q[0];
  assign s    = pulse_q[1];
  assign e    = pulse_q[2];
  assign w    = pulse_q[3];
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dir_button_conditioner.sv
// ============================================================================
// Module   : tb_dir_button_conditioner
// Brief    : Self-checking bench: directed segment table, reset sequences and
//            randomized stimulus against a sliding-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dir_button_conditioner;

  localparam int DB = 4;
  localparam logic [3:0] BN = 4'b0001;
  localparam logic [3:0] BS = 4'b0010;
  localparam logic [3:0] BE = 4'b0100;
  localparam logic [3:0] BW = 4'b1000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0;
  logic n, s, e, w, busy;

  always #5 clk = ~clk;

  dir_button_conditioner #(.DB_CYCLES(DB)) u_dut (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_n),
    .btn_s (btn_s),
    .btn_e (btn_e),
    .btn_w (btn_w),
    .n     (n),
    .s     (s),
    .e     (e),
    .w     (w),
    .busy  (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: raw samples per edge, most recent at index 0.
  logic [3:0] m_raw [0:DB];
  logic [3:0] m_db;
  logic [3:0] m_pulse;
  logic       m_busy;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    logic [3:0] dir;
    int         at;
    logic       bz;
  } seg_t;

  seg_t tbl[$];

  function automatic logic [4:0] outs();
    return {busy, w, e, s, n};
  endfunction

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void m_clear();
    for (int j = 0; j <= DB; j++) m_raw[j] = 4'b0000;
    m_db    = 4'b0000;
    m_pulse = 4'b0000;
    m_busy  = 1'b0;
  endfunction

  // A level flips once the last DB synchronised samples all disagree with it;
  // the synchroniser makes the sample seen at edge t the raw level of edge t-2.
  function automatic void m_edge(logic [3:0] raw);
    logic [3:0] nd;
    logic [3:0] rises;
    logic       flip;
    nd = m_db;
    for (int ch = 0; ch < 4; ch++) begin
      flip = 1'b1;
      for (int j = 1; j <= DB; j++)
        if (m_raw[j][ch] == m_db[ch]) flip = 1'b0;
      if (flip) nd[ch] = ~m_db[ch];
    end
    rises   = nd & ~m_db;
    m_pulse = 4'b0000;
    for (int ch = 0; ch < 4; ch++) begin
      logic [3:0] others;
      others = m_db & ~(4'b0001 << ch);
      if (rises[ch] && m_pulse == 4'b0000 && others == 4'b0000)
        m_pulse[ch] = 1'b1;
    end
    m_busy = |nd;
    m_db   = nd;
    for (int j = DB; j >= 1; j--) m_raw[j] = m_raw[j-1];
    m_raw[0] = raw;
  endfunction

  task automatic step(input logic [3:0] b, input logic rn);
    {btn_w, btn_e, btn_s, btn_n} = b;
    if (!rn && reset) begin
      reset = 1'b0;
      m_clear();
      #1;
      check("async_reset", {3'b0, outs()}, 8'h00);
    end else begin
      reset = rn;
    end
    @(posedge clk);
    #1;
    if (reset) m_edge(b);
    else       m_clear();
    check("model", {3'b0, outs()}, {3'b0, m_busy, m_pulse});
    check("onehot", {7'b0, ($countones({w, e, s, n}) > 1)}, 8'h00);
  endtask

  task automatic run_seg(input seg_t sg);
    for (int c = 1; c <= sg.hold; c++) begin
      step(sg.btn, 1'b1);
      check("seg_pulse", {4'b0, w, e, s, n}, {4'b0, (c == sg.at) ? sg.dir : 4'b0000});
    end
    check("seg_busy", {7'b0, busy}, {7'b0, sg.bz});
  endtask

  initial begin
    logic [3:0] rb;
    m_clear();
    // clean press, release
    tbl.push_back('{4'b0000,   9, 4'b0000, 0, 1'b0});
    tbl.push_back('{BN,       20, BN,      6, 1'b1});
    tbl.push_back('{4'b0000,  10, 4'b0000, 0, 1'b0});
    // bounce rejection
    tbl.push_back('{BE,        2, 4'b0000, 0, 1'b0});
    tbl.push_back('{4'b0000,   2, 4'b0000, 0, 1'b0});
    tbl.push_back('{BE,        2, 4'b0000, 0, 1'b0});
    tbl.push_back('{4'b0000,   2, 4'b0000, 0, 1'b0});
    tbl.push_back('{BE,       10, BE,      6, 1'b1});
    tbl.push_back('{4'b0000,  10, 4'b0000, 0, 1'b0});
    // hold and release
    tbl.push_back('{BW,      100, BW,      6, 1'b1});
    tbl.push_back('{4'b0000,   5, 4'b0000, 0, 1'b1});
    tbl.push_back('{4'b0000,   5, 4'b0000, 0, 1'b0});
    // simultaneous press
    tbl.push_back('{BS | BE,  12, BS,      6, 1'b1});
    tbl.push_back('{4'b0000,  10, 4'b0000, 0, 1'b0});
    tbl.push_back('{BE,       12, BE,      6, 1'b1});
    tbl.push_back('{4'b0000,  10, 4'b0000, 0, 1'b0});
    // chord lockout
    tbl.push_back('{BE,       10, BE,      6, 1'b1});
    tbl.push_back('{BE | BN,  12, 4'b0000, 0, 1'b1});
    tbl.push_back('{BN,       12, 4'b0000, 0, 1'b1});
    tbl.push_back('{4'b0000,  10, 4'b0000, 0, 1'b0});
    tbl.push_back('{BN,       12, BN,      6, 1'b1});
    tbl.push_back('{4'b0000,  10, 4'b0000, 0, 1'b0});

    // Reset state
    repeat (3) step(4'b0000, 1'b0);
    check("reset_outs", {3'b0, outs()}, 8'h00);

    for (int i = 0; i < tbl.size(); i++) run_seg(tbl[i]);

    // Reset while busy, button held across deassertion
    run_seg('{BN, 8, BN, 6, 1'b1});
    step(BN, 1'b0);
    step(BN, 1'b0);
    run_seg('{BN, 10, BN, 6, 1'b1});
    run_seg('{4'b0000, 10, 4'b0000, 0, 1'b0});

    // Reset mid-debounce discards the partial count
    run_seg('{BN, 5, 4'b0000, 0, 1'b0});
    step(BN, 1'b0);
    step(BN, 1'b0);
    run_seg('{BN, 10, BN, 6, 1'b1});
    run_seg('{4'b0000, 10, 4'b0000, 0, 1'b0});

    // Randomized: sticky levels with occasional bounces and resets
    rb = 4'b0000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) rb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 8) == 0) rb = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) rb = 4'b0000;
      if ($urandom_range(0, 299) == 0) begin
        step(rb, 1'b0);
        step(rb, 1'b0);
      end else begin
        step(rb, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
